// File: rtl/ee201_debounce_pkg.sv
// Shared definitions for the tick-based push-button debouncer.
// Contents: FSM state encoding and parameter range-check helpers.
package ee201_debounce_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    // Fixed encodings keep the state visible in lab waveforms.
    typedef enum logic [STATE_WIDTH-1:0] {
        INI     = 3'b000,
        WQ      = 3'b001,
        SCEN_ST = 3'b010,
        HELD    = 3'b011,
        MCEN_ST = 3'b100,
        CCR     = 3'b101
    } state_t;

    // Counter width must be representable and leave room for the shift below.
    function automatic bit width_in_range(input int unsigned cnt_width);
        return (cnt_width >= 1) && (cnt_width <= 31);
    endfunction

    // A tick count is legal in 1..2^cnt_width so its terminal value fits in cnt.
    function automatic bit ticks_in_range(input int unsigned ticks,
                                          input int unsigned cnt_width);
        return (ticks >= 1) && (64'(ticks) <= (64'd1 << cnt_width));
    endfunction

endpackage

// File: rtl/ee201_sync2.sv
// Two-flop synchronizer for the asynchronous button input.
// Ports: clk (clock), reset (sync, active-high), d (async in), q (synchronized out).
module ee201_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages clear on reset so a held button is re-debounced afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ee201_tick_debouncer.sv
// Push-button debouncer and single/multi-pulser paced by a sample Tick.
// Ports: Clk, Reset (sync, active-high), Tick (sample strobe), PB (raw button),
//        DPB (debounced level), SCEN (one pulse per press),
//        MCEN (pulse at press, then every REPEAT_TICKS Ticks while held).
module ee201_tick_debouncer
    import ee201_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS = 8,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Tick,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN
);

    // Elaboration-time guards on the parameter ranges.
    if (!width_in_range(CNT_WIDTH)) begin : g_bad_width
        $error("CNT_WIDTH out of range");
    end
    if (!ticks_in_range(STABLE_TICKS, CNT_WIDTH)) begin : g_bad_stable
        $error("STABLE_TICKS out of range for CNT_WIDTH");
    end
    if (!ticks_in_range(REPEAT_TICKS, CNT_WIDTH)) begin : g_bad_repeat
        $error("REPEAT_TICKS out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic                 pb_s;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dpb_d, scen_d, mcen_d;

    ee201_sync2 u_sync (
        .clk   (Clk),
        .reset (Reset),
        .d     (PB),
        .q     (pb_s)
    );

    // State, counter and outputs; outputs are registered from the next-state decode
    // so they equal a Moore decode of the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INI;
            cnt_q   <= '0;
            DPB     <= 1'b0;
            SCEN    <= 1'b0;
            MCEN    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            DPB     <= dpb_d;
            SCEN    <= scen_d;
            MCEN    <= mcen_d;
        end
    end

    // Next state and counter; the pb_s branch always wins over a same-cycle Tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INI: begin
                cnt_d = '0;
                if (pb_s) state_d = WQ;
            end
            WQ: begin
                if (!pb_s) begin
                    state_d = INI;
                    cnt_d   = '0;
                end else if (Tick) begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = SCEN_ST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            SCEN_ST: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            HELD: begin
                if (!pb_s) begin
                    state_d = CCR;
                    cnt_d   = '0;
                end else if (Tick) begin
                    if (cnt_q == REPEAT_LAST) begin
                        state_d = MCEN_ST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            MCEN_ST: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            CCR: begin
                // A short return to 1 here is a release glitch, not a new press.
                if (pb_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (Tick) begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = INI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = INI;
                cnt_d   = '0;
            end
        endcase

        dpb_d  = (state_d == SCEN_ST) || (state_d == HELD) ||
                 (state_d == MCEN_ST) || (state_d == CCR);
        scen_d = (state_d == SCEN_ST);
        mcen_d = (state_d == SCEN_ST) || (state_d == MCEN_ST);
    end

endmodule

// File: tb/tb_ee201_tick_debouncer.sv
// Bench for ee201_tick_debouncer: cycle table with Tick forced, then
// multi-cycle sequences paced by a divide-by-5 tick generator.
module tb_ee201_tick_debouncer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pb = 1'b0;
    logic tick_mode = 1'b1;
    logic tick_force = 1'b1;
    logic tick;
    logic tick_gen;
    logic dpb, scen, mcen;

    int n_assert = 0;
    int n_fail = 0;
    int scen_cyc = 0;
    int mcen_cyc = 0;
    int dpb_low_cyc = 0;
    int dpb_cyc = 0;
    int tcnt = 0;

    always #5 clk = ~clk;

    // Stand-in for ee201_pulse_atN with N=5.
    always @(posedge clk) tcnt <= (tcnt == 4) ? 0 : tcnt + 1;
    assign tick_gen = (tcnt == 4);
    assign tick = tick_mode ? tick_force : tick_gen;

    ee201_tick_debouncer dut (
        .Clk   (clk),
        .Reset (reset),
        .Tick  (tick),
        .PB    (pb),
        .DPB   (dpb),
        .SCEN  (scen),
        .MCEN  (mcen)
    );

    typedef struct {
        logic reset;
        logic pb;
        logic tick;
        logic dpb;
        logic scen;
        logic mcen;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic p, input logic t,
                       input logic d, input logic s, input logic m);
        vec_t v;
        v.reset = r; v.pb = p; v.tick = t; v.dpb = d; v.scen = s; v.mcen = m;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_assert++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock; sample 1 time unit after the edge and accumulate pulse statistics.
    task automatic step();
        @(posedge clk);
        #1;
        if (scen) scen_cyc++;
        if (mcen) mcen_cyc++;
        if (dpb) dpb_cyc++;
        else dpb_low_cyc++;
    endtask

    task automatic clear_counts();
        scen_cyc = 0; mcen_cyc = 0; dpb_low_cyc = 0; dpb_cyc = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pb = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_scen(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!scen && k < 60);
    endtask

    initial begin
        int k;

        // Tick forced to 1: exact per-edge expectations (edge numbers in comments).
        add(6, 0, 1, 1, 0, 0, 0);   // e1-e6: sync + WQ count
        add(1, 0, 1, 1, 1, 1, 1);   // e7: SCEN_ST
        add(8, 0, 1, 1, 1, 0, 0);   // e8-e15: HELD counting
        add(1, 0, 1, 1, 1, 0, 1);   // e16: MCEN_ST
        add(1, 0, 1, 1, 1, 0, 0);   // e17: HELD
        add(6, 0, 0, 1, 1, 0, 0);   // e18-e23: sync fall, CCR counting
        add(2, 0, 0, 1, 0, 0, 0);   // e24-e25: INI
        add(10, 0, 1, 0, 0, 0, 0);  // e26-e35: no Tick, parked in WQ
        add(3, 0, 1, 1, 0, 0, 0);   // e36-e38: WQ counting
        add(1, 0, 1, 1, 1, 1, 1);   // e39: SCEN_ST
        add(1, 0, 1, 1, 1, 0, 0);   // e40: HELD
        add(1, 1, 1, 1, 0, 0, 0);   // e41: reset while held
        add(6, 0, 1, 1, 0, 0, 0);   // e42-e47: re-debounce
        add(1, 0, 1, 1, 1, 1, 1);   // e48: fresh SCEN
        add(2, 0, 1, 1, 1, 0, 0);   // e49-e50

        tick_mode = 1'b1;
        do_reset();
        check("reset_dpb", dpb, 1'b0);
        check("reset_scen", scen, 1'b0);
        check("reset_mcen", mcen, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].reset;
            pb = vecs[i].pb;
            tick_force = vecs[i].tick;
            step();
            check($sformatf("vec%0d_dpb", i + 1), dpb, vecs[i].dpb);
            check($sformatf("vec%0d_scen", i + 1), scen, vecs[i].scen);
            check($sformatf("vec%0d_mcen", i + 1), mcen, vecs[i].mcen);
        end

        // Remaining sequences use the N=5 tick.
        tick_mode = 1'b0;

        // Bounce every 3 clocks never survives a 4-tick quiet window.
        do_reset();
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            pb = ((i / 3) % 2) == 0;
            step();
        end
        pb = 1'b0;
        repeat (20) step();
        check_range("bounce_dpb_cycles", dpb_cyc, 0, 0);
        check_range("bounce_scen_cycles", scen_cyc, 0, 0);
        check_range("bounce_mcen_cycles", mcen_cyc, 0, 0);

        // Clean 200-clock press: 1 SCEN, 5 MCEN, DPB falls 18-23 clocks after PB.
        do_reset();
        clear_counts();
        pb = 1'b1;
        repeat (200) step();
        pb = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (dpb && k < 60);
        check("press_dpb_fell", dpb, 1'b0);
        check_range("press_release_latency", k, 18, 23);
        repeat (10) step();
        check_range("press_scen_cycles", scen_cyc, 1, 1);
        check_range("press_mcen_cycles", mcen_cyc, 5, 5);

        // Release glitch in CCR returns to HELD without dropping DPB or a new SCEN.
        do_reset();
        pb = 1'b1;
        wait_scen(k);
        check("glitch_press_seen", scen, 1'b1);
        repeat (5) step();
        pb = 1'b0;
        repeat (3) step();
        check("glitch_in_ccr_dpb", dpb, 1'b1);
        clear_counts();
        pb = 1'b1;
        repeat (2) step();
        pb = 1'b0;
        repeat (12) step();
        check_range("glitch_dpb_low_cycles", dpb_low_cyc, 0, 0);
        check_range("glitch_scen_cycles", scen_cyc, 0, 0);
        k = 0;
        do begin
            step();
            k++;
        end while (dpb && k < 60);
        check("glitch_final_release", dpb, 1'b0);

        // Reset while in HELD clears outputs; the held button is debounced again.
        do_reset();
        pb = 1'b1;
        wait_scen(k);
        check("midhold_press_seen", scen, 1'b1);
        repeat (10) step();
        check("midhold_held_dpb", dpb, 1'b1);
        reset = 1'b1;
        step();
        check("midhold_reset_dpb", dpb, 1'b0);
        check("midhold_reset_scen", scen, 1'b0);
        check("midhold_reset_mcen", mcen, 1'b0);
        reset = 1'b0;
        wait_scen(k);
        check("midhold_fresh_scen", scen, 1'b1);
        check("midhold_fresh_mcen", mcen, 1'b1);
        check_range("midhold_fresh_latency", k, 18, 23);
        step();
        check("midhold_scen_one_wide", scen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
